// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encoding and the default operand width.
package mdu_ctrl_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } md_state_e;

endpackage

// File: rtl/mdu_hilo.sv
// HI/LO architectural register pair with independent write enables.
module mdu_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] hi_d,
   input  logic [WIDTH-1:0] lo_d,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (hi_we) hi <= hi_d;
         if (lo_we) lo <= lo_d;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and HI/LO ownership.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write directly from here
// MUL   | WIDTH shift-add iterations on the magnitude product
// DIV   | WIDTH restoring-divide iterations on magnitudes
// FIX   | apply signs, write HI/LO (unless divide by zero)
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   md_state_e          state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mcand, quot, divisor, rem;
   logic               sa, sb, is_div, dz_flag;

   logic               op_signed, op_mul, op_div, last_iter;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   logic               hi_we, lo_we;
   logic [WIDTH-1:0]   hi_d, lo_d;

   assign op_signed = (op == MD_MULT) || (op == MD_DIV);
   assign op_mul    = (op == MD_MULT) || (op == MD_MULTU);
   assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);
   assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
   assign last_iter = (cnt == CW'(WIDTH-1));

   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
   assign div_shift = {rem, quot[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, divisor};

   assign prod_fix  = (sa ^ sb) ? -prod : prod;
   assign quot_fix  = (sa ^ sb) ? -quot : quot;
   assign rem_fix   = sa ? -rem : rem;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) begin
            if (op_mul)      state_nx = MUL;
            else if (op_div) state_nx = DIV;
         end
         MUL:  if (last_iter) state_nx = FIX;
         DIV:  if (last_iter) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      hi_we = 1'b0;
      lo_we = 1'b0;
      hi_d  = '0;
      lo_d  = '0;
      case (state)
         IDLE: if (start) begin
            hi_we = (op == MD_MTHI);
            lo_we = (op == MD_MTLO);
            hi_d  = a;
            lo_d  = a;
         end
         FIX: begin
            if (!is_div) begin
               hi_we = 1'b1;
               lo_we = 1'b1;
               hi_d  = prod_fix[2*WIDTH-1:WIDTH];
               lo_d  = prod_fix[WIDTH-1:0];
            end else if (!dz_flag) begin
               hi_we = 1'b1;
               lo_we = 1'b1;
               hi_d  = rem_fix;
               lo_d  = quot_fix;
            end
         end
         default: ;
      endcase
   end

   // Iteration datapath works on magnitudes; signs are applied only in FIX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         prod    <= '0;
         mcand   <= '0;
         quot    <= '0;
         rem     <= '0;
         divisor <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         is_div  <= 1'b0;
         dz_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start && (op_mul || op_div)) begin
               cnt     <= '0;
               sa      <= op_signed & a[WIDTH-1];
               sb      <= op_signed & b[WIDTH-1];
               mcand   <= a_mag;
               prod    <= {{WIDTH{1'b0}}, b_mag};
               quot    <= a_mag;
               rem     <= '0;
               divisor <= b_mag;
               is_div  <= op_div;
               dz_flag <= op_div && (b == '0);
            end
            MUL: begin
               prod <= {mul_sum, prod[WIDTH-1:1]};
               cnt  <= cnt + CW'(1);
            end
            DIV: begin
               if (!div_diff[WIDTH]) begin
                  rem  <= div_diff[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b1};
               end else begin
                  rem  <= div_shift[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
         dz   <= 1'b0;
      end else begin
         done <= (state == FIX);
         dz   <= (state == FIX) && is_div && dz_flag;
      end
   end

   mdu_hilo #(.WIDTH(WIDTH)) u_hilo (
      .clk   (clk),
      .reset (reset),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .hi_d  (hi_d),
      .lo_d  (lo_d),
      .hi    (hi),
      .lo    (lo)
   );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: MD results, latency, divide by zero,
// MTHI/MTLO, start-while-busy, async reset abort and back-to-back issue.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, dz;
   logic [31:0] hi, lo;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mdu_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .dz    (dz),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; issues an MD op and follows it to its done cycle.
   task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz);
      int n;
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ".busy1"}, 64'(busy), 64'd1);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk({tag, ".lat"}, 64'(n), 64'd33);
      chk({tag, ".done"}, 64'(done), 64'd1);
      chk({tag, ".dz"}, 64'(dz), 64'(exp_dz));
      chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
   endtask

   task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] av);
      start = 1'b1; op = o; a = av;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      #12;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.hi", 64'(hi), 64'd0);
      chk("rst.lo", 64'(lo), 64'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      run_md("multu_ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      @(posedge clk); #1;
      chk("done_pulse", 64'(done), 64'd0);
      run_md("mult_m3x7", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run_md("mult_min2", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
      run_md("div_m7d2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_md("divu_7d2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
      run_md("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

      mt("mthi", 3'd4, 32'h11111111);
      chk("mthi.hi", 64'(hi), 64'h11111111);
      mt("mtlo", 3'd5, 32'h22222222);
      chk("mtlo.lo", 64'(lo), 64'h22222222);
      run_md("divu_dz", 3'd3, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1'b1);

      // MTLO issued mid-operation must be dropped
      start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 3'd5; a = 32'h0000ABCD;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk("busy_mtlo.done", 64'(done), 64'd1);
      chk("busy_mtlo.lo", 64'(lo), 64'd15);
      chk("busy_mtlo.hi", 64'(hi), 64'd0);

      mt("mthi5", 3'd4, 32'h5);
      chk("mthi5.hi", 64'(hi), 64'h5);

      // async reset partway through a MULTU
      start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.hi", 64'(hi), 64'd0);
      chk("abort.lo", 64'(lo), 64'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      run_md("post_rst", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
      run_md("b2b", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
